display_scan_driver: RTL

Time-multiplexed 8-digit seven-segment scan driver, downstream of the BCD conversion stage in the 7-segment peripheral. Takes a 32-bit packed nibble value (8 hex/BCD digits), holds it in a frame-synchronous shadow register so a digit never changes mid-frame, and cycles through the digits. It drives one common anode at a time with decoded segments, a decimal point, an anti-ghosting guard interval and optional leading-zero blanking.

---
 rtl/display_scan_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scan driver with a frame-synchronous shadow register,
// anti-ghosting guard interval and optional leading-zero blanking.
module display_scan_driver #(
    parameter int unsigned SCAN_DIV = 10000,
    parameter int unsigned GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        value_valid,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp_n,
    output logic [7:0]  AN,
    output logic        frame_start
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]      digit_idx_q, digit_idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [31:0]     pending_q, pending_d;
    logic            pend_flag_q, pend_flag_d;

    logic [7:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_n_q, dp_n_d;
    logic            frame_start_q, frame_start_d;

    logic            slot_last;
    logic            frame_end;
    logic [3:0]      nibble;
    logic [6:0]      seg_hi;
    logic [7:0]      lz_mask;
    logic            zero_run;
    logic            lit;

    assign slot_last = (slot_cnt_q == LastCnt);
    assign frame_end = slot_last && (digit_idx_q == 3'd7);

    always_comb begin
        slot_cnt_d  = slot_last ? '0 : slot_cnt_q + CntW'(1);
        digit_idx_d = slot_last ? digit_idx_q + 3'd1 : digit_idx_q;
    end

    // A strobe landing on the boundary cycle bypasses pending and goes straight to the shadow.
    always_comb begin
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        if (frame_end) begin
            if (value_valid) begin
                shadow_d = value;
            end else if (pend_flag_q) begin
                shadow_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (value_valid) begin
            pending_d   = value;
            pend_flag_d = 1'b1;
        end
    end

    // lz_mask[k] set when shadow nibbles k..7 are all zero; digit 0 is never blanked.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_run   = zero_run & (shadow_q[k*4 +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    always_comb begin
        nibble = shadow_q[{digit_idx_q, 2'b00} +: 4];
        seg_hi = 7'h00;
        unique case (nibble)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            4'hF: seg_hi = 7'h71;
            default: seg_hi = 7'h00;
        endcase
    end

    always_comb begin
        lit = digit_en[digit_idx_q] && !(blank_lz && lz_mask[digit_idx_q])
              && (slot_cnt_q >= GuardCnt);
        an_d          = lit ? ~(8'h01 << digit_idx_q) : 8'hFF;
        seg_d         = lit ? ~seg_hi : 7'h7F;
        dp_n_d        = lit ? ~dp_in[digit_idx_q] : 1'b1;
        frame_start_d = (digit_idx_q == 3'd0) && (slot_cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= 3'd0;
            shadow_q      <= '0;
            pending_q     <= '0;
            pend_flag_q   <= 1'b0;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            pend_flag_q   <= pend_flag_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign {g, f, e, d, c, b, a} = seg_q;
    assign dp_n        = dp_n_q;
    assign AN          = an_q;
    assign frame_start = frame_start_q;

endmodule
